// File: rtl/kb_scan_ctrl.sv
// PS/2 scan-code sequencer: decodes make/break/extended prefixes, tracks Shift/Caps,
// case-corrects converter output and queues ASCII characters in a FWFT FIFO.
module kb_scan_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_valid,
  input  logic [7:0]        scan_data,
  output logic [7:0]        kb_code,
  input  logic [7:0]        ascii_in,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic [ADDR_W:0]   rx_count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              shift_state,
  output logic              caps_state
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  state_t      state, state_nxt;
  logic [7:0]  kb_code_nxt;
  logic        push_pend, push_pend_nxt;
  logic        lshift, lshift_nxt;
  logic        rshift, rshift_nxt;
  logic        caps_nxt;
  logic        caps_held, caps_held_nxt;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [8:0]        conv;
  logic              push_req, do_push, do_pop;

  // Lowercase letters flip to uppercase when exactly one of Shift/Caps is active.
  function automatic logic [7:0] case_fix(input logic [7:0] ch, input logic upper);
    if (upper && ch >= 8'h61 && ch <= 8'h7A) return ch - 8'h20;
    return ch;
  endfunction

  // Returns {valid, character}; special keys are resolved here, the rest by the converter.
  function automatic logic [8:0] convert(input logic [7:0] code, input logic [7:0] ascii,
                                         input logic upper);
    case (code)
      8'h5A:   return {1'b1, 8'h0D};
      8'h66:   return {1'b1, 8'h08};
      8'h29:   return {1'b1, 8'h20};
      8'h0D:   return {1'b1, 8'h09};
      default: return {(ascii != code), case_fix(ascii, upper)};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      kb_code    <= 8'h00;
      push_pend  <= 1'b0;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      caps_state <= 1'b0;
      caps_held  <= 1'b0;
    end else begin
      state      <= state_nxt;
      kb_code    <= kb_code_nxt;
      push_pend  <= push_pend_nxt;
      lshift     <= lshift_nxt;
      rshift     <= rshift_nxt;
      caps_state <= caps_nxt;
      caps_held  <= caps_held_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    kb_code_nxt   = kb_code;
    push_pend_nxt = 1'b0;
    lshift_nxt    = lshift;
    rshift_nxt    = rshift;
    caps_nxt      = caps_state;
    caps_held_nxt = caps_held;
    if (scan_valid) begin
      case (state)
        S_IDLE: begin
          case (scan_data)
            8'hF0: state_nxt = S_BRK;
            8'hE0: state_nxt = S_EXT;
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
            8'h12: lshift_nxt = 1'b1;
            8'h59: rshift_nxt = 1'b1;
            8'h58: begin
              // Typematic repeats of Caps Lock arrive while held and must not re-toggle.
              if (!caps_held) begin
                caps_nxt      = ~caps_state;
                caps_held_nxt = 1'b1;
              end
            end
            default: begin
              kb_code_nxt   = scan_data;
              push_pend_nxt = 1'b1;
            end
          endcase
        end
        S_BRK: begin
          case (scan_data)
            8'h12:   lshift_nxt    = 1'b0;
            8'h59:   rshift_nxt    = 1'b0;
            8'h58:   caps_held_nxt = 1'b0;
            default: ;
          endcase
          state_nxt = S_IDLE;
        end
        S_EXT: begin
          if (scan_data == 8'hF0)      state_nxt = S_EXT_BRK;
          else if (scan_data != 8'hE0) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign shift_state = lshift | rshift;

  // Conversion stage: ascii_in still reflects the pre-edge kb_code.
  assign conv     = convert(kb_code, ascii_in, shift_state ^ caps_state);
  assign push_req = push_pend & conv[8];
  assign do_pop   = rd_en & (count != '0);
  assign do_push  = push_req & ((count != FULL_CNT) | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= conv[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (push_req && !do_push)    overflow <= 1'b1;
      else if (ovf_clr)            overflow <= 1'b0;
    end
  end

  assign rx_empty = (count == '0);
  assign rx_full  = (count == FULL_CNT);
  assign rx_count = count;
  assign rd_data  = rx_empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// Bench for kb_scan_ctrl: table of scan bytes with expected characters and modifier
// state, an expected-character queue drained through the bus port, and corner sequences.
module tb_kb_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_data = 8'h00;
  logic [7:0] kb_code;
  logic [7:0] ascii_in;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rx_empty, rx_full;
  logic [3:0] rx_count;
  logic       overflow;
  logic       ovf_clr = 1'b0;
  logic       shift_state, caps_state;

  int total = 0;
  int bad   = 0;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0] scan;
    logic [7:0] ch;   // 0 = nothing queued
    logic       sh;
    logic       cp;
    logic       dr;   // drain FIFO after this row
  } vec_t;
  vec_t vt[$];

  kb_scan_ctrl #(.FIFO_DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .scan_valid(scan_valid), .scan_data(scan_data),
    .kb_code(kb_code), .ascii_in(ascii_in), .rd_en(rd_en), .rd_data(rd_data),
    .rx_empty(rx_empty), .rx_full(rx_full), .rx_count(rx_count), .overflow(overflow),
    .ovf_clr(ovf_clr), .shift_state(shift_state), .caps_state(caps_state)
  );

  always #5 clk = ~clk;

  // Small stand-in for the kb2ascii converter; unmapped codes pass through.
  function automatic logic [7:0] kb2ascii(input logic [7:0] c);
    case (c)
      8'h1C: return 8'h61;
      8'h32: return 8'h62;
      8'h21: return 8'h63;
      8'h23: return 8'h64;
      8'h24: return 8'h65;
      8'h16: return 8'h31;
      8'h45: return 8'h30;
      8'h41: return 8'h2C;
      default: return c;
    endcase
  endfunction
  assign ascii_in = kb2ascii(kb_code);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] s, input logic [7:0] c, input logic sh,
                     input logic cp, input logic dr);
    vec_t v;
    v.scan = s; v.ch = c; v.sh = sh; v.cp = cp; v.dr = dr;
    vt.push_back(v);
  endtask

  // Drives one scan byte; optionally pops on the same edge as the resulting push.
  task automatic send(input logic [7:0] b, input logic pop);
    @(negedge clk);
    scan_valid = 1'b1; scan_data = b;
    @(negedge clk);
    scan_valid = 1'b0; rd_en = pop;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) begin
      check({tag, " count"}, rx_count, q.size());
      check({tag, " rd_data"}, rd_data, q[0]);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      void'(q.pop_front());
    end
    check({tag, " empty"}, rx_empty, 1'b1);
    check({tag, " rd_data empty"}, rd_data, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    #12;
    check("rst kb_code", kb_code, 8'h00);
    check("rst empty", rx_empty, 1'b1);
    check("rst full", rx_full, 1'b0);
    check("rst count", rx_count, 0);
    check("rst rd_data", rd_data, 8'h00);
    check("rst overflow", overflow, 1'b0);
    check("rst shift", shift_state, 1'b0);
    check("rst caps", caps_state, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: kb_code after edge N, push at edge N+1
    @(negedge clk);
    scan_valid = 1'b1; scan_data = 8'h1C;
    @(negedge clk);
    scan_valid = 1'b0;
    check("lat kb_code", kb_code, 8'h1C);
    check("lat count0", rx_count, 0);
    @(negedge clk);
    check("lat count1", rx_count, 1);
    check("lat rd_data", rd_data, 8'h61);
    q.push_back(8'h61);
    drain("t1");

    // Table: scan, expected char, shift, caps, drain
    add(8'h12, 8'h00, 1, 0, 0);
    add(8'h1C, 8'h41, 1, 0, 0);
    add(8'hF0, 8'h00, 1, 0, 0);
    add(8'h12, 8'h00, 0, 0, 0);
    add(8'h1C, 8'h61, 0, 0, 1);
    add(8'h58, 8'h00, 0, 1, 0);
    add(8'h58, 8'h00, 0, 1, 0);
    add(8'hF0, 8'h00, 0, 1, 0);
    add(8'h58, 8'h00, 0, 1, 0);
    add(8'h32, 8'h42, 0, 1, 0);
    add(8'h58, 8'h00, 0, 0, 0);
    add(8'hF0, 8'h00, 0, 0, 0);
    add(8'h58, 8'h00, 0, 0, 0);
    add(8'h12, 8'h00, 1, 0, 0);
    add(8'h32, 8'h42, 1, 0, 0);
    add(8'hF0, 8'h00, 1, 0, 0);
    add(8'h12, 8'h00, 0, 0, 1);
    add(8'hE0, 8'h00, 0, 0, 0);
    add(8'h75, 8'h00, 0, 0, 0);
    add(8'hE0, 8'h00, 0, 0, 0);
    add(8'hF0, 8'h00, 0, 0, 0);
    add(8'h75, 8'h00, 0, 0, 0);
    add(8'h16, 8'h31, 0, 0, 0);
    add(8'h05, 8'h00, 0, 0, 0);
    add(8'hAA, 8'h00, 0, 0, 0);
    add(8'hFA, 8'h00, 0, 0, 0);
    add(8'h5A, 8'h0D, 0, 0, 0);
    add(8'h29, 8'h20, 0, 0, 0);
    add(8'h66, 8'h08, 0, 0, 0);
    add(8'h0D, 8'h09, 0, 0, 1);
    add(8'h58, 8'h00, 0, 1, 0);
    add(8'hF0, 8'h00, 0, 1, 0);
    add(8'h58, 8'h00, 0, 1, 0);
    add(8'h59, 8'h00, 1, 1, 0);
    add(8'h1C, 8'h61, 1, 1, 0);
    add(8'h16, 8'h31, 1, 1, 0);
    add(8'hF0, 8'h00, 1, 1, 0);
    add(8'h59, 8'h00, 0, 1, 0);
    add(8'h21, 8'h43, 0, 1, 0);
    add(8'h58, 8'h00, 0, 0, 0);
    add(8'hF0, 8'h00, 0, 0, 0);
    add(8'h58, 8'h00, 0, 0, 1);
    for (int i = 0; i < vt.size(); i++) begin
      send(vt[i].scan, 1'b0);
      if (vt[i].ch != 8'h00) q.push_back(vt[i].ch);
      check($sformatf("row%0d shift", i), shift_state, vt[i].sh);
      check($sformatf("row%0d caps", i), caps_state, vt[i].cp);
      check($sformatf("row%0d count", i), rx_count, q.size());
      if (vt[i].dr) drain($sformatf("row%0d", i));
    end

    // Back-to-back scan bytes
    @(negedge clk);
    scan_valid = 1'b1; scan_data = 8'h1C;
    @(negedge clk);
    scan_data = 8'h32;
    @(negedge clk);
    scan_valid = 1'b0;
    @(negedge clk);
    q.push_back(8'h61); q.push_back(8'h62);
    drain("b2b");

    // Push with pop on an empty FIFO, then at count=1
    send(8'h23, 1'b1);
    check("empty pushpop count", rx_count, 1);
    check("empty pushpop data", rd_data, 8'h64);
    send(8'h24, 1'b1);
    check("one pushpop count", rx_count, 1);
    check("one pushpop data", rd_data, 8'h65);
    q.push_back(8'h65);
    drain("pushpop");

    // Overflow
    send(8'h1C, 1'b0); send(8'h32, 1'b0); send(8'h21, 1'b0); send(8'h23, 1'b0);
    send(8'h24, 1'b0); send(8'h16, 1'b0); send(8'h45, 1'b0); send(8'h41, 1'b0);
    q.push_back(8'h61); q.push_back(8'h62); q.push_back(8'h63); q.push_back(8'h64);
    q.push_back(8'h65); q.push_back(8'h31); q.push_back(8'h30); q.push_back(8'h2C);
    check("full8 overflow", overflow, 1'b0);
    send(8'h1C, 1'b0);
    check("ovf full", rx_full, 1'b1);
    check("ovf count", rx_count, 8);
    check("ovf flag", overflow, 1'b1);
    check("ovf head", rd_data, 8'h61);
    send(8'h32, 1'b1);
    void'(q.pop_front());
    q.push_back(8'h62);
    check("full pushpop count", rx_count, 8);
    check("full pushpop ovf", overflow, 1'b1);
    check("full pushpop head", rd_data, 8'h62);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 1'b0);
    drain("ovf");

    // Asynchronous reset while a push is pending, with Caps latched
    send(8'h58, 1'b0);
    check("pre-rst caps", caps_state, 1'b1);
    @(negedge clk);
    scan_valid = 1'b1; scan_data = 8'h1C;
    @(negedge clk);
    scan_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst kb_code", kb_code, 8'h00);
    check("arst caps", caps_state, 1'b0);
    check("arst empty", rx_empty, 1'b1);
    @(negedge clk);
    check("arst count", rx_count, 0);
    check("arst rd_data", rd_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst empty", rx_empty, 1'b1);
    send(8'h58, 1'b0);
    check("post-rst caps toggles", caps_state, 1'b1);
    send(8'h32, 1'b0);
    q.push_back(8'h42);
    drain("post-rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
